id_fetch_ctrl: RTL
==================

// Module: id_fetch_ctrl
// PURPOSE
//  - Consumer side of the fetch interface: IF/ID pipeline latch plus control back to fetch.
//  - Captures fetch PC/IR each cycle and resolves BEQ/BNE/J in ID.
//  - Drives is_stall, is_branch and branch_addr back into the fetch stage.
//  - Sits between the fetch stage and the EX-side decode/register-read logic.
// PARAMETERS
//  WIDTH   32  datapath width; PC is WIDTH-2 bits (word address)
//  CNT_W   16  width of the performance counters (STALL_CNT_EN only)
// PORTS
//  clk          in   1         clock, posedge
//  rst_n        in   1         asynchronous, active-low reset
//  if_pc        in   WIDTH-2   PC presented by fetch
//  if_ir        in   WIDTH     instruction presented by fetch; 0 = bubble/NOP
//  is_stall     out  1         hold fetch PC this cycle
//  is_branch    out  1         redirect fetch this cycle
//  branch_addr  out  WIDTH-2   redirect target
//  rs_addr      out  5         id_ir[25:21], to register file
//  rt_addr      out  5         id_ir[20:16], to register file
//  rs_data      in   WIDTH     register file read data for rs
//  rt_data      in   WIDTH     register file read data for rt
//  ex_valid     in   1         EX stage holds a real instruction
//  ex_wr_en     in   1         EX instruction writes a register
//  ex_is_load   in   1         EX instruction is LW
//  ex_rd        in   5         EX destination register
//  id_pc        out  WIDTH-2   latched PC
//  id_ir        out  WIDTH     latched instruction
//  id_valid     out  1         id_ir is consumable by EX this cycle
//  stall_cycles out  CNT_W     STALL_CNT_EN only
//  flush_count  out  CNT_W     STALL_CNT_EN only
// BEHAVIOUR
//  - Instruction fields:
//      op = ir[31:26], rs = ir[25:21], rt = ir[20:16], imm = ir[15:0], jidx = ir[25:0].
//  - Reset (async): id_pc = 0, id_ir = 0, id_valid = 0, counters = 0.
//    Combinational outputs follow from the cleared registers: is_stall = 0, is_branch = 0.
//    A mid-operation reset discards the latched instruction with no flush pulse.
//  - Latch register update on posedge clk, in priority order:
//      1. is_stall: hold id_pc and id_ir.
//      2. is_branch: flush, id_ir <= 0, id_valid <= 0. Fetch zeroes IR in the same cycle anyway.
//      3. Otherwise: id_pc <= if_pc, id_ir <= if_ir, id_valid <= 1.
//  - Stall (combinational from the latch and the ex_* inputs), with r = ex_rd, r != 0, ex_valid = 1:
//      - Load-use: ex_is_load and (r == rs, or r == rt and op is BEQ/BNE).
//      - Branch-operand: op is BEQ/BNE, ex_wr_en, and r matches rs or rt (no forwarding into ID).
//      - Register 0 never causes a stall.
//  - Branch:
//      - taken = !is_stall & id_valid & (BEQ & rs_data == rt_data | BNE & rs_data != rt_data | J).
//      - Stall has priority: is_branch is forced to 0 while stalled.
//      - BEQ/BNE target = id_pc + 1 + sext(imm), truncated to WIDTH-2 bits; wrap-around is legal.
//      - J target = {id_pc[WIDTH-3:26], jidx}.
//      - branch_addr = 0 when is_branch = 0.
//  - Latency: a branch resolves one cycle after fetch presents it; penalty is one bubble.
//    is_branch is a single-cycle pulse, because the next latched instruction is the 0 bubble.
//  - EX-bound valid: id_valid is gated to 0 externally-visibly while is_stall = 1.
//    EX therefore receives a bubble for each stall cycle.
//  - An unknown opcode is passed through unchanged and never branches.
// CONFIGURATION
//  STALL_CNT_EN
//  - Defined:
//      - stall_cycles increments each cycle is_stall = 1.
//      - flush_count increments each cycle is_branch = 1.
//      - Both counters saturate at 2^CNT_W-1 and are cleared by reset.
//  - Undefined: both ports and counters are absent.
// STRUCTURE
//  - Shared header params.v:
//      - WIDTH define.
//      - Opcode defines OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_LW = 6'h23.
//      - Field-position defines.
//  - Sub-module branch_resolve (combinational):
//      - Inputs: op, imm, jidx, id_pc, rs_data, rt_data.
//      - Outputs: taken, target.
//  - Hazard detect and the latch remain in id_fetch_ctrl.
// TESTING
//  - Reset: hold rst_n = 0 mid-stream.
//      -> id_ir = 0, id_valid = 0, is_branch = 0, is_stall = 0 immediately (async).
//  - Straight-line: if_pc = 5, if_ir = 0x00221820.
//      -> next cycle id_pc = 5, id_ir = 0x00221820, id_valid = 1, no stall, no branch.
//  - BEQ taken: id_pc = 10, imm = 0xFFFE, rs_data == rt_data.
//      -> is_branch = 1, branch_addr = 9 for one cycle; next id_ir = 0, id_valid = 0.
//  - Load-use: ex_valid = 1, ex_is_load = 1, ex_rd = 3, ID rs = 3.
//      -> is_stall = 1, latch held, EX-bound valid = 0; releases when ex_valid drops.
//  - Stall vs branch: BNE with rs = 4, ex_wr_en = 1, ex_rd = 4.
//      -> is_stall = 1, is_branch = 0; when the hazard clears, branch resolves.
//  - Edge cases:
//      - J with id_pc = 0x3FFFFFFF, jidx = 0 -> branch_addr = 0x3C000000.
//      - ex_rd = 0 -> no stall.
//      - STALL_CNT_EN: counters saturate at 0xFFFF.

Source files
------------

// File: rtl/id_fetch_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module      : id_fetch_ctrl_pkg
// Description : Opcodes, instruction field decode and defaults for the IF/ID latch.
// Revision    : 1.0 - initial release
// =============================================================================
package id_fetch_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [5:0] {
    OP_J   = 6'h02,
    OP_BEQ = 6'h04,
    OP_BNE = 6'h05,
    OP_LW  = 6'h23
  } opcode_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [25:0] jidx;
  } instr_t;

  function automatic instr_t decode(input logic [31:0] ir);
    instr_t f;
    f.op   = ir[31:26];
    f.rs   = ir[25:21];
    f.rt   = ir[20:16];
    f.imm  = ir[15:0];
    f.jidx = ir[25:0];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_fetch_ctrl_branch_resolve.sv
`default_nettype none
// =============================================================================
// Module      : id_fetch_ctrl_branch_resolve
// Description : Combinational BEQ/BNE/J decision and word-address target.
// Revision    : 1.0 - initial release
// =============================================================================
module id_fetch_ctrl_branch_resolve
  import id_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [5:0]       op,
  input  logic [15:0]      imm,
  input  logic [25:0]      jidx,
  input  logic [WIDTH-3:0] id_pc,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             taken,
  output logic [WIDTH-3:0] target
);

  localparam int PC_W = WIDTH - 2;

  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] seq_pc;

  always_comb begin
    imm_sext = {{(PC_W-16){imm[15]}}, imm};
    seq_pc   = id_pc + PC_W'(1);
    taken    = 1'b0;
    target   = '0;
    case (op)
      OP_BEQ: begin
        taken  = (rs_data == rt_data);
        target = seq_pc + imm_sext;
      end
      OP_BNE: begin
        taken  = (rs_data != rt_data);
        target = seq_pc + imm_sext;
      end
      OP_J: begin
        taken  = 1'b1;
        target = {id_pc[PC_W-1:26], jidx};
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_fetch_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : id_fetch_ctrl
// Description : IF/ID latch with hazard stall and branch redirect back to fetch.
//               Optional STALL_CNT_EN adds saturating stall/flush counters.
// Revision    : 1.0 - initial release
// =============================================================================
module id_fetch_ctrl
  import id_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef STALL_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-3:0] if_pc,
  input  logic [WIDTH-1:0] if_ir,
  output logic             is_stall,
  output logic             is_branch,
  output logic [WIDTH-3:0] branch_addr,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             ex_valid,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  output logic [WIDTH-3:0] id_pc,
  output logic [WIDTH-1:0] id_ir,
  output logic             id_valid
`ifdef STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_count
`endif
);

  logic [WIDTH-3:0] id_pc_q, id_pc_d;
  logic [WIDTH-1:0] id_ir_q, id_ir_d;
  logic             id_valid_q, id_valid_d;

  instr_t           f;
  logic             is_cond_br;
  logic             rd_live;
  logic             load_use;
  logic             br_operand;
  logic             br_taken;
  logic [WIDTH-3:0] br_target;

  assign f          = decode(id_ir_q[31:0]);
  assign is_cond_br = (f.op == OP_BEQ) || (f.op == OP_BNE);

  // ID compares operands itself, so any in-flight writer of a branch source stalls.
  assign rd_live    = ex_valid && (ex_rd != 5'd0);
  assign load_use   = ex_is_load && ((ex_rd == f.rs) || ((ex_rd == f.rt) && is_cond_br));
  assign br_operand = is_cond_br && ex_wr_en && ((ex_rd == f.rs) || (ex_rd == f.rt));
  assign is_stall   = rd_live && (load_use || br_operand);

  id_fetch_ctrl_branch_resolve #(
    .WIDTH (WIDTH)
  ) u_branch_resolve (
    .op      (f.op),
    .imm     (f.imm),
    .jidx    (f.jidx),
    .id_pc   (id_pc_q),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .taken   (br_taken),
    .target  (br_target)
  );

  assign is_branch   = !is_stall && id_valid_q && br_taken;
  assign branch_addr = is_branch ? br_target : '0;

  assign rs_addr  = f.rs;
  assign rt_addr  = f.rt;
  assign id_pc    = id_pc_q;
  assign id_ir    = id_ir_q;
  assign id_valid = id_valid_q && !is_stall;

  always_comb begin
    id_pc_d    = id_pc_q;
    id_ir_d    = id_ir_q;
    id_valid_d = id_valid_q;
    if (is_stall) begin
      id_pc_d    = id_pc_q;
      id_ir_d    = id_ir_q;
      id_valid_d = id_valid_q;
    end else if (is_branch) begin
      id_ir_d    = '0;
      id_valid_d = 1'b0;
    end else begin
      id_pc_d    = if_pc;
      id_ir_d    = if_ir;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc_q    <= '0;
      id_ir_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_ir_q    <= id_ir_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q,  flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (is_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (is_branch && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
`default_nettype wire
